// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_rd_ctrl : async FIFO read-domain pointer, sync chain and level flags   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module fifo_rd_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   wptr_gray,
  input  logic              rd_en,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W:0]   rptr_gray,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              underflow
);

  localparam int            PW     = ADDR_W + 1;
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;

  logic [PW-1:0] wsync;
  logic [PW-1:0] wbin;
  logic [PW-1:0] rbin_q,  rbin_d;
  logic [PW-1:0] rgray_q, rgray_d;
  logic [PW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          ae_q,    ae_d;
  logic          uf_q,    uf_d;
  logic          rd_fire;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Plain flop chain: every bit is resampled each clk, no logic between stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], wptr_gray};
    end
  end

  assign wsync = sync_q[SYNC_STAGES-1];
  assign wbin  = gray2bin(wsync);

  always_comb begin
    rd_fire = rd_en & ~empty_q;
    rbin_d  = rbin_q + {{(PW-1){1'b0}}, rd_fire};
    rgray_d = rbin_d ^ (rbin_d >> 1);
    // Flags use the post-read pointer so back-to-back reads never see a stale level.
    empty_d = (rgray_d == wsync);
    level_d = wbin - rbin_d;
    ae_d    = (level_d <= AE_LVL);
    uf_d    = uf_q | (rd_en & empty_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      uf_q    <= 1'b0;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      level_q <= level_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
      uf_q    <= uf_d;
    end
  end

  assign raddr        = rbin_q[ADDR_W-1:0];
  assign rptr_gray    = rgray_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign level        = level_q;
  assign underflow    = uf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fifo_rd_ctrl : randomized bench with a behavioural FIFO occupancy model  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_fifo_rd_ctrl;

  localparam int ADDR_W = 4;
  localparam int SYNC   = 2;
  localparam int AE     = 2;
  localparam int DEPTH  = 16;
  localparam int MODP   = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] wptr_gray = 5'd0;
  logic       rd_en = 1'b0;
  logic [3:0] raddr;
  logic [4:0] rptr_gray;
  logic       empty;
  logic       almost_empty;
  logic [4:0] level;
  logic       underflow;

  int n_checks = 0;
  int n_pass   = 0;

  fifo_rd_ctrl #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC), .AE_THRESH(AE)) dut (
    .clk(clk), .rst(rst), .wptr_gray(wptr_gray), .rd_en(rd_en),
    .raddr(raddr), .rptr_gray(rptr_gray), .empty(empty),
    .almost_empty(almost_empty), .level(level), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int from_gray(input int g);
    int b = 0;
    for (int i = 4; i >= 0; i--) b = b | ((((b >> (i + 1)) & 1) ^ ((g >> i) & 1)) << i);
    return b;
  endfunction

  // Model: entries visible = (write count seen SYNC edges ago) - read count, mod 2*DEPTH.
  int m_rb = 0, m_lvl = 0;
  bit m_empty = 1'b1, m_ae = 1'b1, m_uf = 1'b0;
  int hist [SYNC+1];
  int wr = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rb = 0; m_lvl = 0; m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0;
      for (int i = 0; i <= SYNC; i++) hist[i] = 0;
    end else begin
      if (rd_en && m_empty) m_uf = 1'b1;
      if (rd_en && !m_empty) m_rb = (m_rb + 1) % MODP;
      for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'(wptr_gray);
      m_lvl   = (from_gray(hist[SYNC]) - m_rb + MODP) % MODP;
      m_empty = (m_lvl == 0);
      m_ae    = (m_lvl <= AE);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic cmp_all();
    check("raddr",        32'(raddr),        32'(m_rb % DEPTH));
    check("rptr_gray",    32'(rptr_gray),    32'(to_gray(m_rb)));
    check("empty",        32'(empty),        32'(m_empty));
    check("almost_empty", 32'(almost_empty), 32'(m_ae));
    check("level",        32'(level),        32'(m_lvl));
    check("underflow",    32'(underflow),    32'(m_uf));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cmp_all();
  endtask

  task automatic set_wr(input int v);
    wr = v % MODP;
    wptr_gray = 5'(to_gray(wr));
  endtask

  task automatic do_reset();
    rst = 1'b1; rd_en = 1'b0; set_wr(0);
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    int saved, tries;
    // T1: reset held with a live write pointer and a read request
    rst = 1'b1; rd_en = 1'b1; set_wr(2);
    tick(); tick();
    check("t1_empty", 32'(empty), 1);
    check("t1_level", 32'(level), 0);
    check("t1_ae",    32'(almost_empty), 1);
    check("t1_raddr", 32'(raddr), 0);
    check("t1_uf",    32'(underflow), 0);
    rd_en = 1'b0; rst = 1'b0;
    tick(); tick();
    check("t1_empty_e2", 32'(empty), 1);
    tick();
    check("t1_empty_e3", 32'(empty), 0);
    check("t1_level_e3", 32'(level), 2);

    // T2: fill to DEPTH, then drain back-to-back
    do_reset();
    for (int k = 1; k <= DEPTH; k++) begin
      set_wr(k);
      repeat (4) tick();
    end
    check("t2_level16", 32'(level), 16);
    check("t2_ae16",    32'(almost_empty), 0);
    rd_en = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      check("t2_raddr", 32'(raddr), 32'(k));
      tick();
      check("t2_lvl_drain", 32'(level), 32'(DEPTH - 1 - k));
    end
    rd_en = 1'b0;
    check("t2_empty", 32'(empty), 1);
    tick();

    // T3: single write/read pairs across the pointer wrap
    for (int k = 0; k < 40; k++) begin
      set_wr(wr + 1);
      tries = 0;
      while (m_empty && tries < 10) begin tick(); tries++; end
      check("t3_sync_bound", 32'(tries < 10), 1);
      check("t3_lvl_le1", 32'(level <= 1), 1);
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    tick(); tick(); tick();
    check("t3_no_uf", 32'(underflow), 0);

    // Random traffic that never reads while empty
    for (int k = 0; k < 300; k++) begin
      rd_en = m_empty ? 1'b0 : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1 && ((wr - m_rb + MODP) % MODP) < DEPTH) set_wr(wr + 1);
      tick();
    end
    rd_en = 1'b0;
    repeat (4) tick();
    while (!m_empty) begin rd_en = 1'b1; tick(); end
    rd_en = 1'b0;
    check("rand_no_uf", 32'(underflow), 0);

    // T5: read fires on the edge where the synced pointer advances
    for (int k = 0; k < 3; k++) set_wr(wr + 1);
    set_wr(wr);
    repeat (4) tick();
    check("t5_lvl3", 32'(level), 3);
    saved = m_rb;
    set_wr(wr + 1);
    tick(); tick();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t5_lvl_same", 32'(level), 3);
    check("t5_raddr",    32'(raddr), 32'((saved + 1) % DEPTH));
    while (!m_empty) begin rd_en = 1'b1; tick(); end
    rd_en = 1'b0;

    // T4: underflow is sticky and does not move the pointer
    saved = m_rb;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t4_uf", 32'(underflow), 1);
    repeat (3) tick();
    check("t4_uf_held",  32'(underflow), 1);
    check("t4_raddr",    32'(raddr), 32'(saved % DEPTH));
    check("t4_rptr",     32'(rptr_gray), 32'(to_gray(saved)));

    // T6: asynchronous reset in the middle of a drain
    do_reset();
    check("t6_uf_clr", 32'(underflow), 0);
    for (int k = 0; k < 12; k++) begin set_wr(wr + 1); tick(); end
    repeat (4) tick();
    tries = 0;
    while (m_lvl != 7 && tries < 20) begin rd_en = 1'b1; tick(); tries++; end
    rd_en = 1'b1;
    check("t6_lvl7", 32'(level), 7);
    #2 rst = 1'b1;
    #1;
    check("t6_empty", 32'(empty), 1);
    check("t6_level", 32'(level), 0);
    check("t6_ae",    32'(almost_empty), 1);
    check("t6_raddr", 32'(raddr), 0);
    check("t6_rptr",  32'(rptr_gray), 0);
    check("t6_uf",    32'(underflow), 0);
    rd_en = 1'b0; set_wr(0);
    tick(); tick();
    rst = 1'b0;

    // Free random traffic, including reads while empty
    for (int k = 0; k < 300; k++) begin
      rd_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0 && ((wr - m_rb + MODP) % MODP) < DEPTH) set_wr(wr + 1);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
